// File: rtl/aes_decipher_core_pkg.sv
// Shared constants for the AES inverse cipher: control-state encodings,
// round counts and the inverse S-box.
package aes_decipher_core_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'd0,
    CTRL_INIT  = 2'd1,
    CTRL_MAIN  = 2'd2,
    CTRL_FINAL = 2'd3
  } ctrl_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_256 = 4'd14;

  // Index 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/aes_decipher_core_inv_mixcolumn.sv
// InvMixColumns on one 32-bit column (top byte is row 0), built from an
// xtime chain so x9/x11/x13/x14 share the x2/x4/x8 terms.
module aes_decipher_core_inv_mixcolumn (
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a [4];
  logic [7:0] m9 [4];
  logic [7:0] m11 [4];
  logic [7:0] m13 [4];
  logic [7:0] m14 [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      a[i]   = col[31 - 8*i -: 8];
      x2     = xt(a[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    mixed[31:24] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
    mixed[23:16] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
    mixed[15:8]  = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
    mixed[7:0]   = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
  end

endmodule

// File: rtl/aes_decipher_core.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys
// requested from the shared key memory in descending order.
module aes_decipher_core
  import aes_decipher_core_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  ctrl_e        ctrl_reg, ctrl_new;
  logic [127:0] state_reg, state_new;
  logic [3:0]   round_ctr, ctr_new;
  logic         keylen_reg, keylen_new;
  logic         ready_reg, ready_new;

  logic [127:0] sub_xor;
  logic [127:0] mix_out;

  // Byte k of the state sits at bits [127-8k -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) begin
      o[127 - 8*k -: 8] = inv_sbox(s[127 - 8*k -: 8]);
    end
    return o;
  endfunction

  assign sub_xor = inv_sub_bytes(inv_shift_rows(state_reg)) ^ round_key;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_decipher_core_inv_mixcolumn u_mix (
      .col   (sub_xor[127 - 32*c -: 32]),
      .mixed (mix_out[127 - 32*c -: 32])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg   <= CTRL_IDLE;
      state_reg  <= '0;
      round_ctr  <= '0;
      keylen_reg <= 1'b0;
      ready_reg  <= 1'b1;
    end else begin
      ctrl_reg   <= ctrl_new;
      state_reg  <= state_new;
      round_ctr  <= ctr_new;
      keylen_reg <= keylen_new;
      ready_reg  <= ready_new;
    end
  end

  always_comb begin
    ctrl_new   = ctrl_reg;
    state_new  = state_reg;
    ctr_new    = round_ctr;
    keylen_new = keylen_reg;
    ready_new  = ready_reg;
    round      = 4'd0;
    case (ctrl_reg)
      CTRL_IDLE: begin
        if (next) begin
          state_new  = block;
          keylen_new = keylen;
          ctr_new    = (keylen ? NR_256 : NR_128) - 4'd1;
          ready_new  = 1'b0;
          ctrl_new   = CTRL_INIT;
        end
      end
      CTRL_INIT: begin
        round     = keylen_reg ? NR_256 : NR_128;
        state_new = state_reg ^ round_key;
        ctrl_new  = CTRL_MAIN;
      end
      CTRL_MAIN: begin
        round     = round_ctr;
        state_new = mix_out;
        ctr_new   = round_ctr - 4'd1;
        if (round_ctr == 4'd1) ctrl_new = CTRL_FINAL;
      end
      CTRL_FINAL: begin
        state_new = sub_xor;
        ready_new = 1'b1;
        ctrl_new  = CTRL_IDLE;
      end
      default: ctrl_new = CTRL_IDLE;
    endcase
  end

  assign new_block = state_reg;
  assign ready     = ready_reg;

endmodule
